// File: rtl/ram_req_ctrl_pkg.sv
// Shared types and defaults for the RAM request controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_req_ctrl_pkg;

    localparam int               DEF_ADDR_W     = 2;
    localparam int               DEF_DATA_W     = 8;
    localparam logic [7:0]       DEF_INIT_VALUE = 8'h00;

    // Controller sequencing states; INIT is only reachable when the
    // post-reset clear feature is compiled in.
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WR,
        RD,
        CAP,
        RSP
    } state_e;

endpackage

// File: rtl/ram_req_ctrl.sv
// Request-side controller owning the address/data_in/write_enable ports of a synchronous RAM.
// Latency: write occupies 2 cycles; read response valid 3 cycles after the request handshake.
// Backpressure: one request in flight; req_ready low until the write retires or rsp is accepted.
// Optional post-reset clear of every location is enabled by defining RAM_REQ_CTRL_INIT_EN.
module ram_req_ctrl
    import ram_req_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(DEF_INIT_VALUE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                we_q, we_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                init_done_q, init_done_d;

`ifdef RAM_REQ_CTRL_INIT_EN
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    localparam state_e   RESET_STATE = INIT;
`else
    localparam state_e   RESET_STATE = IDLE;
    // The clear value only matters when the init walk is built in.
    logic                unused_init_value;
    assign unused_init_value = ^INIT_VALUE;
`endif

    assign req_ready        = (state_q == IDLE) && init_done_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rdata_q;
    assign init_done        = init_done_q;
    assign ram_address      = addr_q;
    assign ram_data_in      = din_q;
    assign ram_write_enable = we_q;

    // Next-state and registered-output decode; write enable defaults low so it
    // can only pulse from a write handshake or an init step.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        din_d       = din_q;
        we_d        = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        init_done_d = init_done_q;
`ifdef RAM_REQ_CTRL_INIT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
`ifdef RAM_REQ_CTRL_INIT_EN
            INIT: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                din_d  = INIT_VALUE;
                // Counter parks on the last address instead of wrapping.
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            IDLE: begin
                // First IDLE edge marks init complete (the last init write,
                // if any, is retiring in this cycle).
                init_done_d = 1'b1;
                if (req_valid && req_ready) begin
                    addr_d = req_addr;
                    din_d  = req_wdata;
                    if (req_write) begin
                        we_d    = 1'b1;
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD: begin
                // RAM registers data_out at the end of this cycle.
                state_d = CAP;
            end
            CAP: begin
                rdata_d     = ram_data_out;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            init_done_q <= 1'b0;
`ifdef RAM_REQ_CTRL_INIT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            init_done_q <= init_done_d;
`ifdef RAM_REQ_CTRL_INIT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl with a behavioural 4x8 synchronous RAM alongside it.
// Latency: n/a.
// Backpressure: randomized rsp_ready stalls.
module tb_ram_req_ctrl;

    localparam int         AW   = 2;
    localparam int         DW   = 8;
    localparam logic [7:0] INITV = 8'h00;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic          ram_write_enable;
    logic [DW-1:0] ram_data_out;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ref_mem [4];
    logic [DW-1:0] ram_mem [4];

    ram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INIT_VALUE(INITV)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .init_done        (init_done),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_data_out     (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sibling synchronous RAM: write on enable, registered read of current address.
    always @(posedge clk) begin
        if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
        ram_data_out <= ram_mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (req_ready) break;
            tick();
        end
        check("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0; req_write = 1'b0; req_wdata = $urandom;
        check("wr_we_high", 32'(ram_write_enable), 32'd1);
        check("wr_addr", 32'(ram_address), 32'(a));
        check("wr_data", 32'(ram_data_in), 32'(d));
        check("wr_busy", 32'(req_ready), 32'd0);
        ref_mem[a] = d;
        tick();
        check("wr_we_low", 32'(ram_write_enable), 32'd0);
        check("wr_ready_again", 32'(req_ready), 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int stall);
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = $urandom;
        tick();
        req_valid = 1'b0;
        // rsp_ready toggles here are meaningless while no response is valid
        rsp_ready = 1'($urandom);
        check("rd_t1_no_rsp", 32'(rsp_valid), 32'd0);
        check("rd_t1_we", 32'(ram_write_enable), 32'd0);
        tick();
        rsp_ready = 1'($urandom);
        check("rd_t2_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        rsp_ready = 1'b0;
        check("rd_t3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_t3_data", 32'(rsp_rdata), 32'(ref_mem[a]));
        check("rd_t3_busy", 32'(req_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("rd_hold_valid", 32'(rsp_valid), 32'd1);
            check("rd_hold_data", 32'(rsp_rdata), 32'(ref_mem[a]));
            check("rd_hold_busy", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd_done_valid", 32'(rsp_valid), 32'd0);
        check("rd_done_ready", 32'(req_ready), 32'd1);
    endtask

    // Called right after rst_n releases (1 time unit past an edge).
    task automatic check_init();
`ifdef RAM_REQ_CTRL_INIT_EN
        for (int k = 0; k < 4; k++) begin
            tick();
            check("init_we", 32'(ram_write_enable), 32'd1);
            check("init_addr", 32'(ram_address), 32'(k));
            check("init_data", 32'(ram_data_in), 32'(INITV));
            check("init_done_low", 32'(init_done), 32'd0);
            check("init_ready_low", 32'(req_ready), 32'd0);
        end
        tick();
        check("init_we_off", 32'(ram_write_enable), 32'd0);
        check("init_done_high", 32'(init_done), 32'd1);
        check("init_ready_high", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) ref_mem[k] = INITV;
`else
        tick();
        check("noinit_done", 32'(init_done), 32'd1);
        check("noinit_ready", 32'(req_ready), 32'd1);
        check("noinit_we", 32'(ram_write_enable), 32'd0);
`endif
    endtask

    initial begin
        logic [7:0] bb_data [4];
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) ram_mem[k] = 8'($urandom);
        repeat (3) tick();

        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_din", 32'(ram_data_in), 32'd0);
        check("rst_we", 32'(ram_write_enable), 32'd0);

        rst_n = 1'b1;
        check_init();

`ifdef RAM_REQ_CTRL_INIT_EN
        for (int k = 0; k < 4; k++) do_read(2'(k), 0);
`else
        // Contents are undefined after reset; give every location a known value.
        for (int k = 0; k < 4; k++) do_write(2'(k), 8'($urandom));
`endif

        do_write(2'd2, 8'hA5);
        do_read(2'd2, 0);

        do_write(2'd1, 8'h3C);
        do_read(2'd1, 5);

        // Back-to-back writes with req_valid held high: accepted every 2 cycles.
        bb_data[0] = 8'h11; bb_data[1] = 8'h22; bb_data[2] = 8'h33; bb_data[3] = 8'h44;
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr = 2'(k); req_wdata = bb_data[k];
            check("b2b_ready", 32'(req_ready), 32'd1);
            tick();
            check("b2b_we", 32'(ram_write_enable), 32'd1);
            check("b2b_addr", 32'(ram_address), 32'(k));
            check("b2b_data", 32'(ram_data_in), 32'(bb_data[k]));
            check("b2b_busy", 32'(req_ready), 32'd0);
            ref_mem[k] = bb_data[k];
            tick();
        end
        req_valid = 1'b0; req_write = 1'b0;
        for (int k = 0; k < 4; k++) do_read(2'(k), 0);

        // Randomized mix of writes and stalled reads against the reference memory.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) do_write(2'($urandom), 8'($urandom));
            else do_read(2'($urandom), int'($urandom_range(0, 3)));
        end

        do_write(2'd3, 8'hFF);
        do_read(2'd3, 1);

        // Reset asserted while the read is in CAP.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd3;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_we", 32'(ram_write_enable), 32'd0);
        check("midrst_rdata", 32'(rsp_rdata), 32'd0);
        check("midrst_init_done", 32'(init_done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        check_init();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        for (int k = 0; k < 4; k++) do_read(2'(k), 0);
        do_write(2'd3, 8'hFF);
        do_read(2'd3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so a stuck handshake can never hang the run.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
